// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//   Shared definitions for the clock design: the mode encoding used by the
//   clock top, seven-segment glyphs (active-low, ordered {g,f,e,d,c,b,a}),
//   field range limits and a BCD-digit-to-segment decoder.
// -----------------------------------------------------------------------------
package clock_pkg;

  // Operating mode of the clock top.
  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_HOURS = 2'd1,
    MODE_SET_MINS  = 2'd2,
    MODE_SET_ALARM = 2'd3
  } clock_mode_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [5:0] MAX_HOURS  = 6'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;

  // Non-decimal codes render as a dark digit.
  function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_of_digit = SEG_0;
      4'd1:    seg_of_digit = SEG_1;
      4'd2:    seg_of_digit = SEG_2;
      4'd3:    seg_of_digit = SEG_3;
      4'd4:    seg_of_digit = SEG_4;
      4'd5:    seg_of_digit = SEG_5;
      4'd6:    seg_of_digit = SEG_6;
      4'd7:    seg_of_digit = SEG_7;
      4'd8:    seg_of_digit = SEG_8;
      4'd9:    seg_of_digit = SEG_9;
      default: seg_of_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/time_display_scanner_if.sv
// -----------------------------------------------------------------------------
// time_display_scanner_if
//   Time bus from the clock top into the display scanner, plus the display
//   pins the scanner drives.
//     hours[4:0], mins[5:0], secs[5:0]  binary time
//     view        0: HH.MM, 1: MM.SS
//     blink_en    [1] blink left field, [0] blink right field
//     an[3:0]     anode enables, active-low, an[0] = rightmost digit
//     seg[6:0]    {g,f,e,d,c,b,a}, active-low
//     dp          decimal point, active-low
//   master: time source (drives time, observes display)
//   slave : display scanner
// -----------------------------------------------------------------------------
interface time_display_scanner_if;
  logic [4:0] hours;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       view;
  logic [1:0] blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output hours, mins, secs, view, blink_en,
    input  an, seg, dp
  );

  modport slave (
    input  hours, mins, secs, view, blink_en,
    output an, seg, dp
  );
endinterface

// File: rtl/bin2bcd_2digit.sv
// -----------------------------------------------------------------------------
// bin2bcd_2digit
//   Combinational 6-bit binary to two BCD digits with a range flag.
//     i_value[5:0]  binary value
//     i_limit[5:0]  largest legal value for this field
//     o_tens[3:0]   tens digit
//     o_units[3:0]  units digit
//     o_oor         i_value > i_limit
//   Digits are still produced for values up to 63; the caller decides what to
//   show when o_oor is set.
// -----------------------------------------------------------------------------
module bin2bcd_2digit (
  input  logic [5:0] i_value,
  input  logic [5:0] i_limit,
  output logic [3:0] o_tens,
  output logic [3:0] o_units,
  output logic       o_oor
);

  logic [5:0] w_rem;

  // Largest multiple of ten not above the value selects the tens digit.
  always_comb begin
    o_tens = 4'd0;
    w_rem  = i_value;
    for (int k = 1; k <= 6; k++) begin
      if (i_value >= 6'(10 * k)) begin
        o_tens = 4'(k);
        w_rem  = i_value - 6'(10 * k);
      end
    end
  end

  assign o_units = 4'(w_rem);
  assign o_oor   = (i_value > i_limit);

endmodule

// File: rtl/time_display_scanner.sv
// -----------------------------------------------------------------------------
// time_display_scanner
//   Drives a 4-digit multiplexed common-anode seven-segment display from the
//   binary time bus. Inputs are captured once per frame into shadow registers
//   so a frame never mixes two time values.
//     clk    system clock
//     reset  asynchronous reset, active-high
//     bus    time_display_scanner_if.slave (time in, an/seg/dp out)
//   Digit order: digit3 = left tens ... digit0 = right units.
//   Outputs are registered: they reflect the scan position one clock later.
// -----------------------------------------------------------------------------
module time_display_scanner
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLINK_HZ     = 2,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  time_display_scanner_if.slave  bus
);

  localparam int DIGIT_TICKS = CLK_HZ / REFRESH_HZ;
  localparam int HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
  localparam int TICK_W      = $clog2(DIGIT_TICKS);
  localparam int BLINK_W     = $clog2(HALF_PERIOD + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0]  TICK_BLANK = TICK_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF_PERIOD - 1);

  // Scan and blink timing
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [1:0]         r_digit_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;

  // Per-frame snapshot of the bus
  logic [4:0] r_hours;
  logic [5:0] r_mins;
  logic [5:0] r_secs;
  logic       r_view;
  logic [1:0] r_blink_en;

  // Registered display pins
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  logic       w_tick_wrap;
  logic       w_frame_wrap;
  logic       w_field;
  logic [3:0] w_bcd;
  logic [3:0] w_an_next;
  logic [6:0] w_seg_next;
  logic       w_dp_next;

  // Field index 1 = left pair, 0 = right pair.
  logic [5:0] w_val   [2];
  logic [5:0] w_lim   [2];
  logic [3:0] w_tens  [2];
  logic [3:0] w_units [2];
  logic       w_oor   [2];

  assign w_tick_wrap  = (r_tick_cnt == TICK_LAST);
  assign w_frame_wrap = w_tick_wrap && (r_digit_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt    <= '0;
      r_digit_idx   <= 2'd0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
      if (w_tick_wrap) begin
        r_digit_idx <= r_digit_idx + 2'd1;
      end
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Snapshot lands together with the 3->0 digit wrap, so digit0 of the new
  // frame is the first slot decoded from the new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hours    <= '0;
      r_mins     <= '0;
      r_secs     <= '0;
      r_view     <= 1'b0;
      r_blink_en <= 2'b00;
    end else if (w_frame_wrap) begin
      r_hours    <= bus.hours;
      r_mins     <= bus.mins;
      r_secs     <= bus.secs;
      r_view     <= bus.view;
      r_blink_en <= bus.blink_en;
    end
  end

  always_comb begin
    w_val[1] = r_view ? r_mins : {1'b0, r_hours};
    w_lim[1] = r_view ? MAX_MINSEC : MAX_HOURS;
    w_val[0] = r_view ? r_secs : r_mins;
    w_lim[0] = MAX_MINSEC;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_field
      bin2bcd_2digit u_conv (
        .i_value (w_val[gi]),
        .i_limit (w_lim[gi]),
        .o_tens  (w_tens[gi]),
        .o_units (w_units[gi]),
        .o_oor   (w_oor[gi])
      );
    end
  endgenerate

  // Blanking for blink wins over the out-of-range dash.
  always_comb begin
    w_field    = r_digit_idx[1];
    w_bcd      = r_digit_idx[0] ? w_tens[w_field] : w_units[w_field];
    w_seg_next = seg_of_digit(w_bcd);
    if (w_oor[w_field]) begin
      w_seg_next = SEG_DASH;
    end
    if (r_blink_phase && r_blink_en[w_field]) begin
      w_seg_next = SEG_BLANK;
    end

    // The colon stand-in on digit2 pulses in HH.MM view, steady in MM.SS.
    w_dp_next = 1'b1;
    if (r_digit_idx == 2'd2) begin
      w_dp_next = r_view ? 1'b0 : r_blink_phase;
    end

    // Anodes stay off for the first ticks of each slot so the old segment
    // pattern never flashes on the new digit.
    w_an_next = (r_tick_cnt < TICK_BLANK) ? 4'b1111 : ~(4'b0001 << r_digit_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_time_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_time_display_scanner
//   Directed bench: 4 clocks per digit slot, 16 per frame, 20-clock blink
//   half-period, 1 blank cycle per slot. Frame f, digit d, tick t of the
//   output sequence appears after posedge number 16f+4d+t+1 counted from the
//   last reset release. Blink phase seen at posedge k is ((k-1)/20) mod 2.
// -----------------------------------------------------------------------------
module tb_time_display_scanner;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  time_display_scanner_if u_if ();

  time_display_scanner #(
    .CLK_HZ       (1000),
    .REFRESH_HZ   (250),
    .BLINK_HZ     (25),
    .BLANK_CYCLES (1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Returns at the negedge following posedge k.
  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (edge_n < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    assert (edge_n == k) else begin
      failures++;
      $error("FAIL sync observed=%0d expected=%0d", edge_n, k);
    end
  endtask

  task automatic check_slot(input int f, input int d, input logic [6:0] seg_exp, input logic dp_exp);
    for (int t = 0; t < 4; t++) begin
      logic [3:0] an_exp;
      wait_edge(16 * f + 4 * d + t + 1);
      an_exp = (t == 0) ? 4'b1111 : ~(4'b0001 << d);
      chk($sformatf("an f%0d d%0d t%0d", f, d, t), {3'b000, u_if.an}, {3'b000, an_exp});
      chk($sformatf("seg f%0d d%0d t%0d", f, d, t), u_if.seg, seg_exp);
      chk($sformatf("dp f%0d d%0d t%0d", f, d, t), {6'd0, u_if.dp}, {6'd0, dp_exp});
    end
    $display("slot frame=%0d digit=%0d seg=%b dp=%b", f, d, seg_exp, dp_exp);
  endtask

  task automatic check_frame(input int f, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0, input logic dp2);
    check_slot(f, 0, s0, 1'b1);
    check_slot(f, 1, s1, 1'b1);
    check_slot(f, 2, s2, dp2);
    check_slot(f, 3, s3, 1'b1);
  endtask

  initial begin
    reset         = 1'b1;
    u_if.hours    = 5'd0;
    u_if.mins     = 6'd0;
    u_if.secs     = 6'd0;
    u_if.view     = 1'b0;
    u_if.blink_en = 2'b00;

    // Reset values, then 00.00 on the first frame.
    repeat (3) @(negedge clk);
    chk("reset an", {3'b000, u_if.an}, 7'b0001111);
    chk("reset seg", u_if.seg, BLANK);
    chk("reset dp", {6'd0, u_if.dp}, 7'd1);
    $display("reset held: an=%b seg=%b dp=%b", u_if.an, u_if.seg, u_if.dp);
    reset = 1'b0;

    // 12:34 applied during frame 0 is only visible from frame 1.
    u_if.hours = 5'd12;
    u_if.mins  = 6'd34;
    check_frame(0, S0, S0, S0, S0, 1'b0);
    check_frame(1, S1, S2, S3, S4, 1'b1);

    // Mid-frame change is deferred to the next frame.
    check_slot(2, 0, S4, 1'b1);
    u_if.mins = 6'd35;
    check_slot(2, 1, S3, 1'b1);
    check_slot(2, 2, S2, 1'b0);
    check_slot(2, 3, S1, 1'b1);

    check_slot(3, 0, S5, 1'b1);
    check_slot(3, 1, S3, 1'b1);
    u_if.hours = 5'd25;
    u_if.mins  = 6'd7;
    check_slot(3, 2, S2, 1'b0);
    check_slot(3, 3, S1, 1'b1);

    // Out-of-range hours show dashes.
    check_slot(4, 0, S7, 1'b1);
    check_slot(4, 1, S0, 1'b1);
    u_if.view     = 1'b1;
    u_if.mins     = 6'd59;
    u_if.secs     = 6'd0;
    u_if.blink_en = 2'b01;
    check_slot(4, 2, DASH, 1'b1);
    check_slot(4, 3, DASH, 1'b1);

    // MM.SS with the right field blinking.
    check_frame(5, S5, S9, S0, S0, 1'b0);
    check_slot(6, 0, S0, 1'b1);
    check_slot(6, 1, BLANK, 1'b1);
    check_slot(6, 2, S9, 1'b0);
    check_slot(6, 3, S5, 1'b1);
    check_slot(7, 0, BLANK, 1'b1);
    check_slot(7, 1, BLANK, 1'b1);
    check_slot(7, 2, S9, 1'b0);
    check_slot(7, 3, S5, 1'b1);
    check_frame(8, S5, S9, S0, S0, 1'b0);
    check_slot(9, 0, BLANK, 1'b1);

    // One-clock reset in the middle of digit2.
    wait_edge(154);
    chk("pre-reset an", {3'b000, u_if.an}, 7'b0001011);
    chk("pre-reset seg", u_if.seg, S9);
    reset = 1'b1;
    #1;
    chk("async reset an", {3'b000, u_if.an}, 7'b0001111);
    chk("async reset seg", u_if.seg, BLANK);
    chk("async reset dp", {6'd0, u_if.dp}, 7'd1);
    $display("mid-scan reset: an=%b seg=%b dp=%b", u_if.an, u_if.seg, u_if.dp);
    @(negedge clk);
    reset = 1'b0;

    check_frame(0, S0, S0, S0, S0, 1'b0);
    check_slot(1, 0, S0, 1'b1);
    check_slot(1, 1, BLANK, 1'b1);
    check_slot(1, 2, S9, 1'b0);
    check_slot(1, 3, S5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
